red_pitaya_pwm_mc: RTL



---
 rtl/red_pitaya_pwm_mc.sv | 111 +++++++++++
 1 files changed

// File: rtl/red_pitaya_pwm_mc.sv
// Multi-channel PWM with a shared prescaler and period counter; the fractional duty is
// spread over a frame of 2^DW periods by first-order sigma-delta dithering.
module red_pitaya_pwm_mc #(
    parameter int unsigned NCH = 4,
    parameter int unsigned VW  = 8,
    parameter int unsigned DW  = 4,
    parameter int unsigned PSW = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NCH*(VW+DW)-1:0] cfg,
    input  logic [PSW-1:0]         freq_div,
    input  logic                   center_mode,
    input  logic                   dither_en,
    output logic [NCH-1:0]         pwm_o,
    output logic                   pwm_s,
    output logic                   frame_s
);
    localparam int unsigned CW = VW + DW;

    logic [PSW-1:0] div_cnt;
    logic [PSW-1:0] div_last;
    logic           tick;
    logic [VW-1:0]  vcnt;
    logic [VW-1:0]  cmp;
    logic           dir;
    logic           vmax;
    logic           pend;
    logic           fend;
    logic [DW-1:0]  bcnt;
    logic           mode_act;
    logic           dith_act;
    logic [VW-1:0]  v_act   [NCH];
    logic [DW-1:0]  f_act   [NCH];
    logic [DW-1:0]  acc     [NCH];
    logic [DW:0]    acc_sum [NCH];
    logic [NCH-1:0] carry;
    logic [NCH-1:0] pwm_nxt;

    always_comb begin
        div_last = (freq_div <= PSW'(1)) ? '0 : freq_div - PSW'(1);
        tick     = (div_cnt >= div_last);
        vmax     = (vcnt == {VW{1'b1}});
        cmp      = dir ? ~vcnt : vcnt;
        pend     = tick && vmax && (!mode_act || dir);
        fend     = pend && (!dith_act || (bcnt == {DW{1'b1}}));
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            pwm_nxt[k] = ({1'b0, cmp} < ({1'b0, v_act[k]} + {{VW{1'b0}}, carry[k]}));
            acc_sum[k] = {1'b0, acc[k]} + {1'b0, f_act[k]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
            vcnt    <= '0;
            dir     <= 1'b0;
            bcnt    <= '0;
            pwm_o   <= '0;
            pwm_s   <= 1'b0;
            frame_s <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + PSW'(1);
            // pend/fend already contain tick, so strobes stay low between ticks
            pwm_s   <= pend;
            frame_s <= fend;
            if (tick) begin
                vcnt  <= vcnt + VW'(1);
                pwm_o <= pwm_nxt;
                // every period restarts counting up; only a mid-period wrap turns down
                if (vmax) begin
                    dir <= !pend;
                end
            end
            if (pend) begin
                bcnt <= fend ? '0 : bcnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_act <= 1'b0;
            dith_act <= 1'b0;
            carry    <= '0;
            for (int k = 0; k < NCH; k++) begin
                v_act[k] <= '0;
                f_act[k] <= '0;
                acc[k]   <= '0;
            end
        end else if (fend) begin
            mode_act <= center_mode;
            dith_act <= dither_en;
            carry    <= '0;
            for (int k = 0; k < NCH; k++) begin
                v_act[k] <= cfg[k*CW+DW +: VW];
                f_act[k] <= cfg[k*CW +: DW];
                // seed with one step so the frame's 2^DW additions yield exactly f carries
                acc[k]   <= dither_en ? cfg[k*CW +: DW] : '0;
            end
        end else if (pend && dith_act) begin
            for (int k = 0; k < NCH; k++) begin
                {carry[k], acc[k]} <= acc_sum[k];
            end
        end
    end

endmodule
